// File: rtl/key_conditioner.sv
// Push-button conditioner: polarity normalise, 2-flop synchronise, debounce, strobes.
// `define KEY_TOGGLE_EN makes run_en a press-toggled register; otherwise run_en follows key_level.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic       run_en,
    output logic [7:0] bounce_cnt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Wait-state count on the edge that takes the final matching sample.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // A single sample is enough, so the stable states commit directly.
    localparam bit IMMEDIATE = (DEBOUNCE_CYCLES <= 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [7:0]       bounce_q, bounce_d;
    logic [7:0]       bounce_inc;
    logic             key_norm;
    logic             sync_meta;
    logic             key_sync;

    assign key_norm = key ^ KEY_ACTIVE_LOW;

    // Two-flop synchroniser; both stages reset to the released value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            key_sync  <= 1'b0;
        end else begin
            sync_meta <= key_norm;
            key_sync  <= sync_meta;
        end
    end

    assign bounce_inc = (bounce_q == 8'hFF) ? bounce_q : bounce_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        bounce_d  = bounce_q;
        case (state_q)
            RELEASED: begin
                cnt_d = '0;
                if (key_sync) begin
                    if (IMMEDIATE) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            PRESS_WAIT: begin
                if (!key_sync) begin
                    state_d  = RELEASED;
                    cnt_d    = '0;
                    bounce_d = bounce_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                cnt_d = '0;
                if (!key_sync) begin
                    if (IMMEDIATE) begin
                        state_d   = RELEASED;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                if (key_sync) begin
                    state_d  = PRESSED;
                    cnt_d    = '0;
                    bounce_d = bounce_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            bounce_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            bounce_q  <= bounce_d;
        end
    end

`ifdef KEY_TOGGLE_EN
    logic run_q;

    // Flips on the same edge that registers the press strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else if (press_d) begin
            run_q <= ~run_q;
        end
    end

    assign run_en = run_q;
`else
    assign run_en = level_q;
`endif

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign bounce_cnt  = bounce_q;

endmodule
